// File: rtl/mem_pkg.sv
// Shared types, exception codes and alignment rule for the MEM-stage memory access unit.
package mem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_t;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DISCARD} mem_state_t;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // A dword access is never legal on a 32-bit bus.
    function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] addr_lo,
                                           input int data_w);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0] != 1'b0;
            SZ_W:    return addr_lo[1:0] != 2'b00;
            default: return (addr_lo != 3'b000) || (data_w < 64);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering shared by both directions: store strobes/replication and load extraction/extension.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int LANES = DATA_W / 8,
    localparam int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [LANE_W-1:0] lane,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [LANES-1:0]  wstrb,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [LANES-1:0]  base_strb;
    logic              msb;

    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        shifted   = bus_rdata >> {lane, 3'b000};
        base_strb = '0;
        mask      = '0;
        msb       = 1'b0;
        wdata     = store_data;
        case (mem_size_t'(size))
            SZ_B: begin
                base_strb = LANES'(8'h01);
                wdata     = {LANES{store_data[7:0]}};
                mask      = DATA_W'(8'hFF);
                msb       = shifted[7];
            end
            SZ_H: begin
                base_strb = LANES'(8'h03);
                wdata     = {(LANES / 2){store_data[15:0]}};
                mask      = DATA_W'(16'hFFFF);
                msb       = shifted[15];
            end
            SZ_W: begin
                base_strb = LANES'(8'h0F);
                wdata     = {(LANES / 4){store_data[31:0]}};
                mask      = DATA_W'(32'hFFFF_FFFF);
                msb       = shifted[31];
            end
            default: begin
                base_strb = LANES'(8'hFF);
                wdata     = store_data;
                mask      = '1;
                msb       = shifted[DATA_W-1];
            end
        endcase
        wstrb     = base_strb << lane;
        load_data = (shifted & mask) | ((sign && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: drives a split-transaction bus (req/addr_ok, then data_ok) and returns
// one registered result per op to WB; survives a flush at any point of a transaction.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                load_i,
    input  logic                store_i,
    input  logic [1:0]          size_i,
    input  logic                sign_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [4:0]          wd_i,
    input  logic                wreg_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                out_valid_o,
    output logic [4:0]          wd_o,
    output logic                wreg_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                exc_o,
    output logic [4:0]          exc_code_o,
    output logic [ADDR_W-1:0]   badvaddr_o,
    output logic                bus_req_o,
    output logic                bus_wr_o,
    output logic [1:0]          bus_size_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W/8-1:0] bus_wstrb_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_addr_ok_i,
    input  logic                bus_data_ok_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    mem_state_t        state, state_nxt;
    logic              accept, mem_op, misaligned;
    logic              l_mem, l_store, l_sign, l_wreg;
    mem_size_t         l_size;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata, load_data;
    logic [4:0]        l_wd;
    logic [LANES-1:0]  strb;

    assign ready_o    = (state == ST_IDLE) && !flush_i;
    assign accept     = valid_i && ready_o;
    assign mem_op     = load_i || store_i;
    assign misaligned = is_misaligned(mem_size_t'(size_i), addr_i[2:0], DATA_W);
    assign stall_o    = (state != ST_IDLE) || (accept && mem_op);

    assign bus_req_o   = (state == ST_REQ);
    assign bus_wr_o    = l_store;
    assign bus_size_o  = l_size;
    assign bus_addr_o  = l_addr;
    // Strobes stay zero until the first memory op has been latched.
    assign bus_wstrb_o = strb & {LANES{l_mem}};

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size       (l_size),
        .sign       (l_sign),
        .lane       (l_addr[LANE_W-1:0]),
        .store_data (l_wdata),
        .bus_rdata  (bus_rdata_i),
        .wstrb      (strb),
        .wdata      (bus_wdata_o),
        .load_data  (load_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush after addr_ok must still drain the outstanding data_ok, hence DISCARD.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept && mem_op && !misaligned) state_nxt = ST_REQ;
            ST_REQ: begin
                if (bus_addr_ok_i)  state_nxt = flush_i ? ST_DISCARD : ST_RESP;
                else if (flush_i)   state_nxt = ST_IDLE;
            end
            ST_RESP: begin
                if (bus_data_ok_i)  state_nxt = ST_IDLE;
                else if (flush_i)   state_nxt = ST_DISCARD;
            end
            ST_DISCARD: if (bus_data_ok_i) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_o <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            rdata_o     <= '0;
            exc_o       <= 1'b0;
            exc_code_o  <= '0;
            badvaddr_o  <= '0;
            l_mem       <= 1'b0;
            l_store     <= 1'b0;
            l_sign      <= 1'b0;
            l_size      <= SZ_B;
            l_addr      <= '0;
            l_wdata     <= '0;
            l_wd        <= '0;
            l_wreg      <= 1'b0;
        end else begin
            out_valid_o <= 1'b0;
            if (accept) begin
                if (!mem_op) begin
                    out_valid_o <= 1'b1;
                    rdata_o     <= wdata_i;
                    wd_o        <= wd_i;
                    wreg_o      <= wreg_i;
                    exc_o       <= 1'b0;
                end else if (misaligned) begin
                    out_valid_o <= 1'b1;
                    wd_o        <= wd_i;
                    wreg_o      <= 1'b0;
                    exc_o       <= 1'b1;
                    exc_code_o  <= store_i ? EXC_ADES : EXC_ADEL;
                    badvaddr_o  <= addr_i;
                end else begin
                    l_mem   <= 1'b1;
                    l_store <= store_i;
                    l_sign  <= sign_i;
                    l_size  <= mem_size_t'(size_i);
                    l_addr  <= addr_i;
                    l_wdata <= wdata_i;
                    l_wd    <= wd_i;
                    l_wreg  <= wreg_i;
                end
            end
            if (state == ST_RESP && bus_data_ok_i && !flush_i) begin
                out_valid_o <= 1'b1;
                wd_o        <= l_wd;
                wreg_o      <= l_wreg && !l_store;
                exc_o       <= 1'b0;
                if (!l_store) rdata_o <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Drives a 32-bit and a 64-bit instance with identical ops and compares both against a
// transaction-level model of result timing, lane math, exceptions and flush outcomes.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid = 0, load = 0, store = 0, sign = 0, flush = 0, wreg = 0;
    logic        a_pulse = 0, d_pulse = 0;
    logic [1:0]  size = 0;
    logic [31:0] addr = 0;
    logic [63:0] wdata = 0, bus_rdata = 0;
    logic [4:0]  wd = 0;

    logic        o_ready [2], o_stall [2], o_ov [2], o_wreg [2], o_exc [2], o_req [2], o_wr [2];
    logic [4:0]  o_wd [2], o_code [2];
    logic [31:0] o_bad [2], o_addr [2];
    logic [1:0]  o_size [2];
    logic [7:0]  o_strb [2];
    logic [63:0] o_rdata [2], o_wdata [2];
    logic        aok [2], dok [2], pend [2];

    logic [31:0] a_rdata, a_wdata;
    logic [3:0]  a_strb;
    logic [63:0] b_rdata, b_wdata;
    logic [7:0]  b_strb;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(o_ready[0]),
        .load_i(load), .store_i(store), .size_i(size), .sign_i(sign), .addr_i(addr),
        .wdata_i(wdata[31:0]), .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .stall_o(o_stall[0]),
        .out_valid_o(o_ov[0]), .wd_o(o_wd[0]), .wreg_o(o_wreg[0]), .rdata_o(a_rdata),
        .exc_o(o_exc[0]), .exc_code_o(o_code[0]), .badvaddr_o(o_bad[0]),
        .bus_req_o(o_req[0]), .bus_wr_o(o_wr[0]), .bus_size_o(o_size[0]), .bus_addr_o(o_addr[0]),
        .bus_wstrb_o(a_strb), .bus_wdata_o(a_wdata), .bus_addr_ok_i(aok[0]),
        .bus_data_ok_i(dok[0]), .bus_rdata_i(bus_rdata[31:0])
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(o_ready[1]),
        .load_i(load), .store_i(store), .size_i(size), .sign_i(sign), .addr_i(addr),
        .wdata_i(wdata), .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .stall_o(o_stall[1]),
        .out_valid_o(o_ov[1]), .wd_o(o_wd[1]), .wreg_o(o_wreg[1]), .rdata_o(b_rdata),
        .exc_o(o_exc[1]), .exc_code_o(o_code[1]), .badvaddr_o(o_bad[1]),
        .bus_req_o(o_req[1]), .bus_wr_o(o_wr[1]), .bus_size_o(o_size[1]), .bus_addr_o(o_addr[1]),
        .bus_wstrb_o(b_strb), .bus_wdata_o(b_wdata), .bus_addr_ok_i(aok[1]),
        .bus_data_ok_i(dok[1]), .bus_rdata_i(bus_rdata)
    );

    assign o_rdata[0] = {32'b0, a_rdata};
    assign o_wdata[0] = {32'b0, a_wdata};
    assign o_strb[0]  = {4'b0, a_strb};
    assign o_rdata[1] = b_rdata;
    assign o_wdata[1] = b_wdata;
    assign o_strb[1]  = b_strb;

    // Responsive bus: addr_ok only while requested, data_ok only for an accepted address.
    assign aok[0] = a_pulse && o_req[0];
    assign aok[1] = a_pulse && o_req[1];
    assign dok[0] = d_pulse && pend[0];
    assign dok[1] = d_pulse && pend[1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend[0] <= 1'b0;
            pend[1] <= 1'b0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (dok[u])      pend[u] <= 1'b0;
                else if (aok[u]) pend[u] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] dmask(input int nbits);
        return (nbits >= 64) ? '1 : ((64'd1 << nbits) - 64'd1);
    endfunction

    function automatic bit m_misal(input logic [1:0] sz, input logic [31:0] ad, input int dw);
        return (sz == 2'd3 && dw == 32) || ((ad % (32'd1 << sz)) != 0);
    endfunction

    function automatic logic [63:0] m_strb(input logic [1:0] sz, input logic [31:0] ad, input int dw);
        return (((64'd1 << (1 << sz)) - 64'd1) << (ad % (dw / 8))) & dmask(dw / 8);
    endfunction

    function automatic logic [63:0] m_wdata(input logic [1:0] sz, input logic [63:0] d, input int dw);
        int nb = 8 << sz;
        logic [63:0] r = '0;
        for (int k = 0; k < dw; k += nb) r |= (d & dmask(nb)) << k;
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                                           input logic [63:0] rd, input int dw);
        int nb = 8 << sz;
        logic [63:0] v = ((rd & dmask(dw)) >> (8 * (ad % (dw / 8)))) & dmask(nb);
        if (sg && ((v >> (nb - 1)) & 64'd1) != 0) v |= ~dmask(nb);
        return v & dmask(dw);
    endfunction

    // One op: accept in cycle 0; addr_ok offered in cycle A, data_ok in cycle D; flush in cycle fl (0 = none).
    task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [63:0] wdat, input logic [4:0] dst,
                          input logic we, input int a_dly, input int d_dly, input int fl,
                          input logic [63:0] rd);
        int a_cyc = 1 + a_dly;
        int d_cyc = a_cyc + 1 + d_dly;
        int kind [2], res_c [2], idle_c [2], req_end [2], dw;
        for (int u = 0; u < 2; u++) begin
            dw = u ? 64 : 32;
            kind[u] = !(ld || st) ? 0 : (m_misal(sz, ad, dw) ? 1 : 2);
            if (kind[u] < 2) begin
                res_c[u] = 1; idle_c[u] = 1; req_end[u] = 0;
            end else begin
                res_c[u]   = (fl != 0 && fl <= d_cyc) ? -1 : d_cyc + 1;
                idle_c[u]  = (fl != 0 && fl < a_cyc) ? fl + 1 : d_cyc + 1;
                req_end[u] = (fl != 0 && fl < a_cyc) ? fl : a_cyc;
            end
        end
        @(posedge clk); #1;
        valid = 1; load = ld; store = st; size = sz; sign = sg; addr = ad; wdata = wdat;
        wd = dst; wreg = we; flush = 0; a_pulse = 0; d_pulse = 0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            dw = u ? 64 : 32;
            check($sformatf("ready_accept/%0d", dw), 64'(o_ready[u]), 64'd1);
            if (kind[u] != 1) check($sformatf("stall_accept/%0d", dw), 64'(o_stall[u]), 64'(kind[u] == 2));
        end
        for (int cyc = 1; cyc <= d_cyc + 2; cyc++) begin
            @(posedge clk); #1;
            valid = 0;
            a_pulse = (cyc == a_cyc);
            d_pulse = (cyc == d_cyc);
            flush = (cyc == fl);
            bus_rdata = (cyc == d_cyc) ? rd : {$urandom, $urandom};
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                dw = u ? 64 : 32;
                check($sformatf("stall/%0d c%0d", dw, cyc), 64'(o_stall[u]), 64'(cyc < idle_c[u]));
                check($sformatf("out_valid/%0d c%0d", dw, cyc), 64'(o_ov[u]), 64'(cyc == res_c[u]));
                check($sformatf("bus_req/%0d c%0d", dw, cyc), 64'(o_req[u]),
                      64'(kind[u] == 2 && cyc <= req_end[u]));
                if (kind[u] == 2 && cyc <= req_end[u]) begin
                    check($sformatf("bus_addr/%0d", dw), 64'(o_addr[u]), 64'(ad));
                    check($sformatf("bus_wr/%0d", dw), 64'(o_wr[u]), 64'(st));
                    check($sformatf("bus_size/%0d", dw), 64'(o_size[u]), 64'(sz));
                    check($sformatf("bus_wstrb/%0d", dw), 64'(o_strb[u]), m_strb(sz, ad, dw));
                    check($sformatf("bus_wdata/%0d", dw), o_wdata[u], m_wdata(sz, wdat, dw));
                end
                if (cyc == res_c[u]) begin
                    check($sformatf("exc/%0d", dw), 64'(o_exc[u]), 64'(kind[u] == 1));
                    if (kind[u] == 1) begin
                        check($sformatf("exc_code/%0d", dw), 64'(o_code[u]), st ? 64'h5 : 64'h4);
                        check($sformatf("badvaddr/%0d", dw), 64'(o_bad[u]), 64'(ad));
                        check($sformatf("wreg_exc/%0d", dw), 64'(o_wreg[u]), 64'd0);
                    end else begin
                        check($sformatf("wd/%0d", dw), 64'(o_wd[u]), 64'(dst));
                        check($sformatf("wreg/%0d", dw), 64'(o_wreg[u]), 64'(we && !st));
                        if (kind[u] == 0)
                            check($sformatf("rdata_alu/%0d", dw), o_rdata[u], wdat & dmask(dw));
                        else if (!st)
                            check($sformatf("rdata_load/%0d", dw), o_rdata[u], m_load(sz, sg, ad, rd, dw));
                    end
                end
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s_ready/%0d", tag, u), 64'(o_ready[u]), 64'd1);
            check($sformatf("%s_stall/%0d", tag, u), 64'(o_stall[u]), 64'd0);
            check($sformatf("%s_ov/%0d", tag, u), 64'(o_ov[u]), 64'd0);
            check($sformatf("%s_req/%0d", tag, u), 64'(o_req[u]), 64'd0);
            check($sformatf("%s_rdata/%0d", tag, u), o_rdata[u], 64'd0);
            check($sformatf("%s_wd_wreg/%0d", tag, u), {58'(o_wd[u]), o_wreg[u]}, 64'd0);
            check($sformatf("%s_exc/%0d", tag, u), {o_exc[u], 5'(o_code[u]), o_bad[u]}, 64'd0);
            check($sformatf("%s_bus/%0d", tag, u), {o_addr[u], o_strb[u], o_size[u], o_wr[u]}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        int          a_d, d_d, fl, op;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1;

        run_op(0, 0, 2'd2, 0, 32'h0, 64'h1234_5678, 5'd3, 1, 0, 0, 0, 64'h0);
        run_op(1, 0, 2'd0, 1, 32'h1003, 64'h0, 5'd4, 1, 0, 0, 0, 64'h0000_0000_80FF_0000);
        run_op(0, 1, 2'd1, 0, 32'h2002, 64'hBEEF, 5'd5, 1, 3, 1, 0, 64'h0);
        run_op(1, 0, 2'd2, 0, 32'h3001, 64'h0, 5'd6, 1, 0, 0, 0, 64'h0);
        run_op(0, 1, 2'd2, 0, 32'h3002, 64'h0, 5'd7, 1, 0, 0, 0, 64'h0);
        run_op(1, 0, 2'd2, 0, 32'h400, 64'h0, 5'd8, 1, 0, 3, 3, 64'hDEAD_BEEF);
        run_op(1, 0, 2'd2, 0, 32'h404, 64'h0, 5'd9, 1, 4, 0, 2, 64'h0);
        run_op(1, 0, 2'd2, 0, 32'h408, 64'h0, 5'd9, 1, 1, 1, 2, 64'h0);
        run_op(1, 0, 2'd2, 0, 32'h40C, 64'h0, 5'd9, 1, 0, 1, 3, 64'h0);
        run_op(1, 0, 2'd3, 0, 32'h8, 64'h0, 5'd10, 1, 0, 0, 0, 64'h0123_4567_89AB_CDEF);
        run_op(1, 0, 2'd1, 0, 32'h6, 64'h0, 5'd11, 1, 0, 0, 0, 64'h8001_0000_8001_0000);

        // Flush while IDLE must block the accept.
        @(posedge clk); #1;
        valid = 1; load = 0; store = 0; flush = 1; wdata = 64'h55;
        @(negedge clk);
        for (int u = 0; u < 2; u++) check($sformatf("ready_flush/%0d", u), 64'(o_ready[u]), 64'd0);
        @(posedge clk); #1;
        valid = 0; flush = 0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) check($sformatf("ov_flushed/%0d", u), 64'(o_ov[u]), 64'd0);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 2);
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
            a_d = $urandom_range(0, 3);
            d_d = $urandom_range(0, 3);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, a_d + d_d + 3) : 0;
            run_op(op == 1, op == 2, sz, 1'($urandom), ad, {$urandom, $urandom}, 5'($urandom),
                   1'($urandom), a_d, d_d, fl, {$urandom, $urandom});
        end

        // Asynchronous reset in the middle of RESP.
        @(posedge clk); #1;
        valid = 1; load = 1; store = 0; size = 2'd2; addr = 32'h100; wd = 5'd7; wreg = 1;
        @(posedge clk); #1;
        valid = 0; a_pulse = 1;
        @(posedge clk); #1;
        a_pulse = 0;
        #2;
        rst_n = 0;
        #1;
        check_reset_state("async_reset");
        @(posedge clk); #1;
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
